// File: rtl/sregs_pkg.sv
// Shared definitions for the pcpu special-register block: register map,
// mode/flag bit positions and the interrupt handshake state encoding.
package sregs_pkg;

  // Special-register addresses
  localparam int SR_RT_MODE      = 1;
  localparam int SR_JTR_MODE     = 2;
  localparam int SR_IRQ_PC       = 3;
  localparam int SR_ALU_FLAGS    = 4;
  localparam int SR_IRQ_FLAGS    = 5;
  localparam int SR_IRQ_MASK     = 6;
  localparam int SR_IRQ_PENDING  = 7;
  localparam int SR_IRQ_CAUSE    = 8;
  localparam int SR_MEM_PG_BASE  = 'h10;
  localparam int SR_PROG_PG_BASE = 'h20;

  // rt_mode = {MEMPG, IRQEN, INA, SUP}
  localparam int RT_SUP   = 0;
  localparam int RT_INA   = 1;
  localparam int RT_IRQEN = 2;
  localparam int RT_MEMPG = 3;

  // jtr_mode = {PRGPG, BLM}
  localparam int JT_BLM   = 0;
  localparam int JT_PRGPG = 1;

  // irq_flags = {IINT, SUP, PRGPG, MEMPG}
  localparam int IF_MEMPG = 0;
  localparam int IF_PRGPG = 1;
  localparam int IF_SUP   = 2;
  localparam int IF_IINT  = 3;

  localparam logic [3:0] RT_MODE_RST  = 4'b0001;
  localparam logic [1:0] JTR_MODE_RST = 2'b01;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-first-set priority encoder: the lowest-numbered asserted request wins.
module irq_prio_enc #(
  parameter int N     = 9,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Scan downwards so the last hit, the lowest index, is the one kept.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sregs_irqpg.sv
// pcpu special registers: mode bits, ALU flags, data/program page translation
// and a multi-source interrupt controller with hardware state save/restore.
module sregs_irqpg
  import sregs_pkg::*;
#(
  parameter int NIRQ      = 8,
  parameter int PG_IDX_W  = 4,
  parameter int PHYS_PG_W = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sr_ie,
  input  logic [ADDR_W-1:0]                 sr_sel,
  input  logic [ADDR_W-1:0]                 sr_in,
  output logic [ADDR_W-1:0]                 sr_out,
  input  logic                              jtr_commit,
  output logic                              boot_mode,
  output logic                              instr_mem_over,
  output logic                              irq_en,
  input  logic [NIRQ-1:0]                   irq_in,
  input  logic                              sw_int,
  output logic                              irq_req,
  input  logic                              irq_ack,
  output logic [3:0]                        irq_cause,
  input  logic                              iret,
  input  logic [ADDR_W-1:0]                 pc_in,
  input  logic                              pc_ie,
  input  logic                              pc_inc,
  input  logic [4:0]                        alu_flags_in,
  input  logic                              alu_flags_ie,
  output logic [4:0]                        alu_flags,
  input  logic [ADDR_W-1:0]                 addr_in,
  output logic [ADDR_W-PG_IDX_W+PHYS_PG_W-1:0] addr_out,
  input  logic [ADDR_W-1:0]                 prog_in,
  output logic [ADDR_W-PG_IDX_W+PHYS_PG_W-1:0] prog_out,
  output logic [PHYS_PG_W-1:0]              prog_page_out
);

  localparam int PW    = NIRQ + 1;
  localparam int PG_N  = 1 << PG_IDX_W;
  localparam int OFF_W = ADDR_W - PG_IDX_W;
  localparam int OUT_W = OFF_W + PHYS_PG_W;

  logic [3:0]        rt_mode_reg,     rt_mode_next;
  logic [1:0]        jtr_mode_reg,    jtr_mode_next;
  logic [1:0]        jtr_buf_reg,     jtr_buf_next;
  logic [ADDR_W-1:0] irq_pc_reg,      irq_pc_next;
  logic [4:0]        alu_flags_reg,   alu_flags_next;
  logic [3:0]        irq_flags_reg,   irq_flags_next;
  logic [PW-1:0]     irq_mask_reg,    irq_mask_next;
  logic [PW-1:0]     irq_pending_reg, irq_pending_next;
  logic [3:0]        irq_cause_reg,   irq_cause_next;
  logic [NIRQ-1:0]   irq_prev_reg;
  irq_state_t        state_reg,       state_next;

  logic [PHYS_PG_W-1:0] mem_page_reg  [PG_N];
  logic [PHYS_PG_W-1:0] prog_page_reg [PG_N];

  // Register decode
  logic sel_rt, sel_jtr, sel_pc, sel_alu, sel_flags, sel_mask, sel_pend, sel_cause;
  logic sel_mp, sel_pp, pg_ok, sup;
  logic [PG_IDX_W-1:0] pg_idx;

  assign sel_rt    = (sr_sel == ADDR_W'(SR_RT_MODE));
  assign sel_jtr   = (sr_sel == ADDR_W'(SR_JTR_MODE));
  assign sel_pc    = (sr_sel == ADDR_W'(SR_IRQ_PC));
  assign sel_alu   = (sr_sel == ADDR_W'(SR_ALU_FLAGS));
  assign sel_flags = (sr_sel == ADDR_W'(SR_IRQ_FLAGS));
  assign sel_mask  = (sr_sel == ADDR_W'(SR_IRQ_MASK));
  assign sel_pend  = (sr_sel == ADDR_W'(SR_IRQ_PENDING));
  assign sel_cause = (sr_sel == ADDR_W'(SR_IRQ_CAUSE));
  assign sel_mp    = (sr_sel[ADDR_W-1:4] == (ADDR_W-4)'(SR_MEM_PG_BASE >> 4));
  assign sel_pp    = (sr_sel[ADDR_W-1:4] == (ADDR_W-4)'(SR_PROG_PG_BASE >> 4));
  assign pg_ok     = (int'(sr_sel[3:0]) < PG_N);
  assign pg_idx    = sr_sel[PG_IDX_W-1:0];
  assign sup       = rt_mode_reg[RT_SUP];

  // Interrupt sources and arbitration
  logic [NIRQ-1:0] irq_edge;
  logic [PW-1:0]   irq_active;
  logic            win_valid;
  logic [3:0]      win_idx;

  assign irq_edge   = irq_in & ~irq_prev_reg;
  assign irq_active = irq_pending_reg & irq_mask_reg;

  irq_prio_enc #(
    .N     (PW),
    .IDX_W (4)
  ) u_prio (
    .req   (irq_active),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    rt_mode_next     = rt_mode_reg;
    jtr_mode_next    = jtr_mode_reg;
    jtr_buf_next     = jtr_buf_reg;
    irq_pc_next      = irq_pc_reg;
    alu_flags_next   = alu_flags_reg;
    irq_flags_next   = irq_flags_reg;
    irq_mask_next    = irq_mask_reg;
    irq_pending_next = irq_pending_reg;
    irq_cause_next   = irq_cause_reg;
    state_next       = state_reg;

    if (sr_ie) begin
      if (sel_rt && sup)   rt_mode_next     = sr_in[3:0];
      if (sel_jtr)         jtr_buf_next     = sr_in[1:0];
      if (sel_pc)          irq_pc_next      = sr_in;
      if (sel_alu)         alu_flags_next   = sr_in[4:0];
      if (sel_mask && sup) irq_mask_next    = sr_in[PW-1:0];
      if (sel_pend)        irq_pending_next = irq_pending_next & ~sr_in[PW-1:0];
    end
    if (alu_flags_ie) alu_flags_next = alu_flags_in;
    if (jtr_commit)   jtr_mode_next  = jtr_buf_reg;

    if (iret && state_reg == ST_IDLE) begin
      rt_mode_next[RT_SUP]    = irq_flags_reg[IF_SUP];
      rt_mode_next[RT_MEMPG]  = irq_flags_reg[IF_MEMPG];
      rt_mode_next[RT_IRQEN]  = 1'b1;
      jtr_mode_next[JT_PRGPG] = irq_flags_reg[IF_PRGPG];
      jtr_buf_next[JT_PRGPG]  = irq_flags_reg[IF_PRGPG];
    end

    unique case (state_reg)
      ST_IDLE: begin
        if (rt_mode_reg[RT_IRQEN] && win_valid) begin
          irq_cause_next = win_idx;
          state_next     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          irq_flags_next[IF_MEMPG] = rt_mode_reg[RT_MEMPG];
          irq_flags_next[IF_PRGPG] = jtr_mode_reg[JT_PRGPG];
          irq_flags_next[IF_SUP]   = rt_mode_reg[RT_SUP];
          irq_flags_next[IF_IINT]  = (irq_cause_reg == 4'(NIRQ));
          // Entry state replaces any same-cycle software write.
          rt_mode_next             = rt_mode_reg;
          rt_mode_next[RT_SUP]     = 1'b1;
          rt_mode_next[RT_IRQEN]   = 1'b0;
          rt_mode_next[RT_MEMPG]   = 1'b0;
          jtr_mode_next[JT_PRGPG]  = 1'b0;
          jtr_buf_next             = jtr_buf_reg;
          jtr_buf_next[JT_PRGPG]   = 1'b0;
          if (pc_ie)       irq_pc_next = sr_in;
          else if (pc_inc) irq_pc_next = pc_in + ADDR_W'(1);
          else             irq_pc_next = pc_in;
          irq_pending_next = irq_pending_next & ~(PW'(1) << irq_cause_reg);
          state_next       = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // New edges are applied last so they win over any clear this cycle.
    irq_pending_next = irq_pending_next | {sw_int, irq_edge};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rt_mode_reg     <= RT_MODE_RST;
      jtr_mode_reg    <= JTR_MODE_RST;
      jtr_buf_reg     <= JTR_MODE_RST;
      irq_pc_reg      <= '0;
      alu_flags_reg   <= '0;
      irq_flags_reg   <= '0;
      irq_mask_reg    <= '0;
      irq_pending_reg <= '0;
      irq_cause_reg   <= '0;
      irq_prev_reg    <= '0;
      state_reg       <= ST_IDLE;
    end else begin
      rt_mode_reg     <= rt_mode_next;
      jtr_mode_reg    <= jtr_mode_next;
      jtr_buf_reg     <= jtr_buf_next;
      irq_pc_reg      <= irq_pc_next;
      alu_flags_reg   <= alu_flags_next;
      irq_flags_reg   <= irq_flags_next;
      irq_mask_reg    <= irq_mask_next;
      irq_pending_reg <= irq_pending_next;
      irq_cause_reg   <= irq_cause_next;
      irq_prev_reg    <= irq_in;
      state_reg       <= state_next;
    end
  end

  // Page tables
  logic [PG_N-1:0] mp_we, pp_we;

  for (genvar gi = 0; gi < PG_N; gi++) begin : g_pg_we
    assign mp_we[gi] = sr_ie && sup && sel_mp && pg_ok && (pg_idx == PG_IDX_W'(gi));
    assign pp_we[gi] = sr_ie && sup && sel_pp && pg_ok && (pg_idx == PG_IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PG_N; i++) begin
        mem_page_reg[i]  <= '0;
        prog_page_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PG_N; i++) begin
        if (mp_we[i]) mem_page_reg[i]  <= sr_in[PHYS_PG_W-1:0];
        if (pp_we[i]) prog_page_reg[i] <= sr_in[PHYS_PG_W-1:0];
      end
    end
  end

  // Read mux
  always_comb begin
    sr_out = '0;
    if (sel_rt)    sr_out = ADDR_W'(rt_mode_reg);
    if (sel_jtr)   sr_out = ADDR_W'(jtr_mode_reg);
    if (sel_pc)    sr_out = irq_pc_reg;
    if (sel_alu)   sr_out = ADDR_W'(alu_flags_reg);
    if (sel_flags) sr_out = ADDR_W'(irq_flags_reg);
    if (sel_mask)  sr_out = ADDR_W'(irq_mask_reg);
    if (sel_pend)  sr_out = ADDR_W'(irq_pending_reg);
    if (sel_cause) sr_out = ADDR_W'(irq_cause_reg);
    if (sel_mp && pg_ok) sr_out = ADDR_W'(mem_page_reg[pg_idx]);
    if (sel_pp && pg_ok) sr_out = ADDR_W'(prog_page_reg[pg_idx]);
  end

  // Address translation
  logic [PHYS_PG_W-1:0] data_pg, prog_pg;

  assign data_pg = mem_page_reg[addr_in[ADDR_W-1 -: PG_IDX_W]];
  assign prog_pg = prog_page_reg[prog_in[ADDR_W-1 -: PG_IDX_W]];

  assign addr_out      = rt_mode_reg[RT_MEMPG]   ? {data_pg, addr_in[OFF_W-1:0]} : OUT_W'(addr_in);
  assign prog_out      = jtr_mode_reg[JT_PRGPG]  ? {prog_pg, prog_in[OFF_W-1:0]} : OUT_W'(prog_in);
  assign prog_page_out = jtr_mode_reg[JT_PRGPG]  ? prog_pg : '0;

  assign boot_mode      = jtr_mode_reg[JT_BLM];
  assign instr_mem_over = rt_mode_reg[RT_INA];
  assign irq_en         = rt_mode_reg[RT_IRQEN];
  assign alu_flags      = alu_flags_reg;
  assign irq_req        = (state_reg == ST_REQ);
  assign irq_cause      = irq_cause_reg;

endmodule

// File: tb/tb_sregs_irqpg.sv
// Directed bench for sregs_irqpg: paging, interrupt handshake, save/restore,
// supervisor write protection, software interrupt and mid-handshake reset.
module tb_sregs_irqpg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sr_ie = 1'b0;
  logic [15:0] sr_sel = '0;
  logic [15:0] sr_in = '0;
  logic [15:0] sr_out;
  logic        jtr_commit = 1'b0;
  logic        boot_mode, instr_mem_over, irq_en;
  logic [7:0]  irq_in = '0;
  logic        sw_int = 1'b0;
  logic        irq_req;
  logic        irq_ack = 1'b0;
  logic [3:0]  irq_cause;
  logic        iret = 1'b0;
  logic [15:0] pc_in = '0;
  logic        pc_ie = 1'b0;
  logic        pc_inc = 1'b0;
  logic [4:0]  alu_flags_in = '0;
  logic        alu_flags_ie = 1'b0;
  logic [4:0]  alu_flags;
  logic [15:0] addr_in = '0;
  logic [19:0] addr_out;
  logic [15:0] prog_in = '0;
  logic [19:0] prog_out;
  logic [7:0]  prog_page_out;

  int n_vec = 0;
  int n_err = 0;

  sregs_irqpg #(
    .NIRQ(8), .PG_IDX_W(4), .PHYS_PG_W(8), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .sr_ie(sr_ie), .sr_sel(sr_sel), .sr_in(sr_in),
    .sr_out(sr_out), .jtr_commit(jtr_commit), .boot_mode(boot_mode),
    .instr_mem_over(instr_mem_over), .irq_en(irq_en), .irq_in(irq_in),
    .sw_int(sw_int), .irq_req(irq_req), .irq_ack(irq_ack),
    .irq_cause(irq_cause), .iret(iret), .pc_in(pc_in), .pc_ie(pc_ie),
    .pc_inc(pc_inc), .alu_flags_in(alu_flags_in), .alu_flags_ie(alu_flags_ie),
    .alu_flags(alu_flags), .addr_in(addr_in), .addr_out(addr_out),
    .prog_in(prog_in), .prog_out(prog_out), .prog_page_out(prog_page_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] sel, input logic [31:0] exp);
    sr_sel = sel;
    #1;
    chk(tag, 32'(sr_out), exp);
  endtask

  task automatic wr(input logic [15:0] sel, input logic [15:0] data);
    sr_ie  = 1'b1;
    sr_sel = sel;
    sr_in  = data;
    tick();
    sr_ie  = 1'b0;
    sr_in  = '0;
    $display("wr sel=0x%02h data=0x%04h", sel, data);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    rd_chk("rst_rt_mode", 16'h01, 32'h1);
    rd_chk("rst_jtr_mode", 16'h02, 32'h1);
    chk("rst_irq_req", 32'(irq_req), 32'h0);
    chk("rst_boot_mode", 32'(boot_mode), 32'h1);
    chk("rst_ina", 32'(instr_mem_over), 32'h0);
    rst = 1'b1;
    tick();

    // Data paging
    wr(16'h13, 16'h0005);
    rd_chk("mem_page3", 16'h13, 32'h05);
    addr_in = 16'h3ABC;
    #1;
    chk("addr_unpaged", 32'(addr_out), 32'h03ABC);
    wr(16'h01, 16'h0009);
    chk("addr_paged", 32'(addr_out), 32'h05ABC);
    wr(16'h21, 16'h0022);

    // ALU flags: ALU write wins over sr write
    sr_ie = 1'b1; sr_sel = 16'h04; sr_in = 16'h001F;
    alu_flags_ie = 1'b1; alu_flags_in = 5'h0A;
    tick();
    sr_ie = 1'b0; alu_flags_ie = 1'b0;
    chk("alu_prio", 32'(alu_flags), 32'h0A);
    wr(16'h04, 16'h0015);
    chk("alu_srwr", 32'(alu_flags), 32'h15);

    // Two sources in one cycle, lowest wins
    wr(16'h01, 16'h000D);
    wr(16'h06, 16'h0024);
    irq_in = 8'h24;
    tick();
    irq_in = 8'h00;
    chk("req_edge_n", 32'(irq_req), 32'h0);
    rd_chk("pend_25", 16'h07, 32'h24);
    tick();
    chk("req_n2", 32'(irq_req), 32'h1);
    chk("cause_2", 32'(irq_cause), 32'h2);
    irq_ack = 1'b1; pc_inc = 1'b1; pc_in = 16'h0100;
    tick();
    irq_ack = 1'b0; pc_inc = 1'b0;
    chk("req_drop", 32'(irq_req), 32'h0);
    rd_chk("irq_pc_inc", 16'h03, 32'h0101);
    rd_chk("rt_entry", 16'h01, 32'h1);
    rd_chk("pend_5", 16'h07, 32'h20);
    rd_chk("flags_save", 16'h05, 32'h5);
    chk("addr_entry", 32'(addr_out), 32'h03ABC);
    tick();
    chk("no_req_irqen0", 32'(irq_req), 32'h0);

    // iret restores, then source 5 is requested
    iret = 1'b1;
    tick();
    iret = 1'b0;
    rd_chk("rt_iret", 16'h01, 32'hD);
    chk("addr_restored", 32'(addr_out), 32'h05ABC);
    chk("req_iret_0", 32'(irq_req), 32'h0);
    tick();
    chk("req_5", 32'(irq_req), 32'h1);
    chk("cause_5", 32'(irq_cause), 32'h5);
    irq_ack = 1'b1; pc_ie = 1'b1; sr_in = 16'h1234;
    tick();
    irq_ack = 1'b0; pc_ie = 1'b0; sr_in = '0;
    rd_chk("irq_pc_jump", 16'h03, 32'h1234);
    rd_chk("pend_none", 16'h07, 32'h0);

    // Supervisor protection
    wr(16'h01, 16'h0000);
    rd_chk("rt_sup0", 16'h01, 32'h0);
    wr(16'h21, 16'h00FF);
    rd_chk("pp1_protected", 16'h21, 32'h22);
    wr(16'h01, 16'h000F);
    rd_chk("rt_protected", 16'h01, 32'h0);
    wr(16'h06, 16'h01FF);
    rd_chk("mask_protected", 16'h06, 32'h24);
    iret = 1'b1;
    tick();
    iret = 1'b0;
    rd_chk("rt_iret2", 16'h01, 32'hD);

    // Software interrupt, mask change during REQ, edge vs clear
    wr(16'h06, 16'h0124);
    sw_int = 1'b1;
    tick();
    sw_int = 1'b0;
    tick();
    chk("req_sw", 32'(irq_req), 32'h1);
    chk("cause_sw", 32'(irq_cause), 32'h8);
    wr(16'h06, 16'h0000);
    chk("req_held", 32'(irq_req), 32'h1);
    chk("cause_held", 32'(irq_cause), 32'h8);
    irq_in = 8'h08;
    wr(16'h07, 16'h0008);
    irq_in = 8'h00;
    rd_chk("edge_beats_w1c", 16'h07, 32'h108);
    irq_ack = 1'b1; pc_in = 16'h0200;
    sr_ie = 1'b1; sr_sel = 16'h03; sr_in = 16'hBEEF;
    tick();
    irq_ack = 1'b0; sr_ie = 1'b0; sr_in = '0;
    rd_chk("irq_pc_ack_wins", 16'h03, 32'h0200);
    rd_chk("flags_iint", 16'h05, 32'hD);
    rd_chk("pend_3", 16'h07, 32'h8);
    chk("irq_en_entry", 32'(irq_en), 32'h0);

    // Reset during REQ
    iret = 1'b1;
    tick();
    iret = 1'b0;
    wr(16'h06, 16'h0008);
    tick();
    chk("req_3", 32'(irq_req), 32'h1);
    chk("cause_3", 32'(irq_cause), 32'h3);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(irq_req), 32'h0);
    rd_chk("rst_mid_pend", 16'h07, 32'h0);
    rd_chk("rst_mid_rt", 16'h01, 32'h1);
    tick();
    rst = 1'b1;
    tick();

    // Program paging via jtr buffer and commit
    wr(16'h21, 16'h0022);
    wr(16'h02, 16'h0002);
    rd_chk("jtr_live", 16'h02, 32'h1);
    prog_in = 16'h1234;
    jtr_commit = 1'b1;
    tick();
    jtr_commit = 1'b0;
    rd_chk("jtr_commit", 16'h02, 32'h2);
    chk("boot_mode_off", 32'(boot_mode), 32'h0);
    chk("prog_out", 32'(prog_out), 32'h22234);
    chk("prog_page_out", 32'(prog_page_out), 32'h22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sregs_irqpg.md
# sregs_irqpg

Parametrised special-register block for the pcpu core. It holds the processor mode registers and the ALU flags, and translates data and program addresses through page tables of configurable size and width. It also contains a multi-source interrupt controller: per-source pending latches, a mask, a fixed-priority arbiter, a request/acknowledge handshake to the pc module, and hardware state save on entry and restore on `iret`. It replaces the single-IRQ special-register block between the decoder/pc module and the memory interface.

## Interface
Parameters:
- NIRQ, 8, number of external interrupt sources (1..15).
- PG_IDX_W, 4, number of page-index bits taken from the top of an address; the tables have 2^PG_IDX_W entries, at most 16.
- PHYS_PG_W, 8, physical page-number width.
- ADDR_W, 16, virtual address and data width.

Ports:
- clk  in  1  core clock; every register updates on its rising edge.
- rst  in  1  reset; asynchronous and active-low (the block is in reset while rst=0).
- sr_ie  in  1  special-register write strobe.
- sr_sel  in  ADDR_W  selects the special register to read or write.
- sr_in  in  ADDR_W  write data; also supplies the jump target when pc_ie is high.
- sr_out  out  ADDR_W  combinational read data for sr_sel.
- jtr_commit  in  1  one-cycle pulse that copies the jtr buffer into jtr_mode.
- boot_mode, instr_mem_over, irq_en  out  1  the BLM, INA and IRQEN mode bits.
- irq_in  in  NIRQ  level interrupt lines; a rising edge sets the matching pending bit.
- sw_int  in  1  software-interrupt pulse.
- irq_req  out  1  interrupt request to the pc module.
- irq_ack  in  1  pc module accepts the request and is jumping to the vector this cycle.
- irq_cause  out  4  number of the source being requested or serviced.
- iret  in  1  one-cycle pulse that restores the saved mode.
- pc_in  in  ADDR_W  current pc.
- pc_ie, pc_inc  in  1  pc module controls, used to compute the return address.
- alu_flags_in  in  5  new flags from the ALU.
- alu_flags_ie  in  1  flag write enable.
- alu_flags  out  5  current flags.
- addr_in  in  ADDR_W  data virtual address.
- addr_out  out  ADDR_W-PG_IDX_W+PHYS_PG_W  data physical address.
- prog_in  in  ADDR_W  program virtual address.
- prog_out  out  ADDR_W-PG_IDX_W+PHYS_PG_W  program physical address.
- prog_page_out  out  PHYS_PG_W  physical page used for the current program address.

## Operation
Special-register map (reads of any other address return 0):
- 1 rt_mode: {MEMPG, IRQEN, INA, SUP}.
- 2 jtr_mode: {PRGPG, BLM}; a write goes to the buffer, a read returns the live value.
- 3 irq_pc.
- 4 alu_flags.
- 5 irq_flags: {IINT, SUP, PRGPG, MEMPG}, read-only.
- 6 irq_mask: NIRQ+1 bits; bit NIRQ masks sw_int.
- 7 irq_pending: write 1 to clear a bit.
- 8 irq_cause.
- 0x10+i: mem_page[i].
- 0x20+i: prog_page[i].

Write rules:
- Writes to rt_mode, irq_mask and the page tables are ignored unless SUP=1.
- A page-table write with i ≥ 2^PG_IDX_W is ignored.

Pending and arbitration:
- Pending bit k is set on a rising edge of irq_in[k].
- Bit NIRQ is set by sw_int; this source reports as cause NIRQ and records IINT=1 in irq_flags.
- Priority is fixed: the lowest-numbered pending, unmasked bit wins.

Interrupt state machine:
- IDLE: when IRQEN=1 and (pending & mask) is non-zero, latch the winning source into irq_cause, raise irq_req and move to REQ.
- REQ: hold irq_req and irq_cause unchanged, even if the mask or pending bits change, until irq_ack.
- On the irq_ack cycle:
  - save irq_flags;
  - set SUP=1 and clear IRQEN, MEMPG and PRGPG (the live PRGPG bit and its buffer copy);
  - clear the serviced pending bit;
  - set irq_pc = sr_in if pc_ie=1, else pc_in+1 if pc_inc=1, else pc_in;
  - drop irq_req and return to IDLE.
- iret restores SUP, MEMPG and PRGPG from irq_flags and sets IRQEN=1. iret while in REQ is ignored.

Address translation:
- When the enable bit is 0 (MEMPG for data, PRGPG for program), the output is the input zero-extended and prog_page_out=0.
- When it is 1, the output is {table[top PG_IDX_W bits], low ADDR_W-PG_IDX_W bits}.

## Timing
- Reset values:
  - rt_mode=0001, jtr_mode and its buffer=01;
  - irq_pc, alu_flags, irq_flags, irq_pending, irq_mask and irq_cause all 0;
  - page tables all 0; state IDLE, irq_req=0.
- Register writes are visible on sr_out the cycle after sr_ie.
- sr_out, addr_out, prog_out and prog_page_out are combinational.
- Edge to request: an irq_in rising edge is sampled at clock edge N, which sets the pending bit; irq_req is high in cycle N+2.
- irq_ack takes effect in a single cycle; irq_req is low in the next cycle.
- Simultaneous events:
  - irq_ack overrides any sr_ie write to rt_mode, jtr_mode or irq_pc in the same cycle.
  - An edge that sets a pending bit wins over a write-1-to-clear of that bit in the same cycle.
  - alu_flags_ie wins over an sr_ie write to register 4.
  - jtr_commit and irq_ack in the same cycle: irq_ack's PRGPG=0 wins.
- Reset asserted mid-handshake returns the block to IDLE immediately and clears all pending bits.

## Structure
- Shared package sregs_pkg:
  - special-register address constants;
  - rt_mode, jtr_mode and irq_flags bit indices;
  - the interrupt state-machine encoding (IDLE, REQ).
- Sub-module irq_prio_enc: parametrised find-first-set over NIRQ+1 bits, producing a valid flag and an index.

## Test plan
- Reset, then write sr 0x13=0x05 and set MEMPG; addr_in=0x3ABC -> addr_out=0x05ABC with defaults.
- Enable IRQEN, unmask sources 2 and 5, pulse both in the same cycle -> irq_req with cause 2; ack while pc_inc=1 and pc_in=0x0100 -> irq_pc=0x0101, SUP=1, IRQEN=0, pending={5}.
- iret after the previous scenario -> IRQEN=1 and saved paging restored; cause 5 requested two cycles later.
- SUP=0, write sr 0x21=0xFF -> prog_page[1] unchanged; write sr 1 -> rt_mode unchanged.
- sw_int with mask bit NIRQ set -> cause=NIRQ and irq_flags IINT=1; mask cleared during REQ -> irq_req held until ack.
- Deassert rst while in REQ -> irq_req=0 immediately, all pending bits 0, rt_mode=0001.
